// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, owner IDs
// and the address legality check.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_S = 1'b1;

  // Rejects word-misaligned addresses and anything beyond the last word.
  function automatic logic addr_reject(input logic [31:0] addr,
                                       input int unsigned depth_words);
    logic [33:0] limit;
    limit = {depth_words, 2'b00};
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port not granted
// last time wins.
import dmem_arb_pkg::*;

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_vld,
  output logic       winner
);

  always_comb begin
    gnt_vld = |req;
    winner  = OWN_C;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = OWN_S;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (port C) and the serial
// loader/debug engine (port S), one transaction every three cycles.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_ack,
  output logic [31:0] s_rdata,
  output logic        s_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  logic [1:0]  state;
  logic        last_grant;
  logic        owner_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] c_rdata_q;
  logic [31:0] s_rdata_q;

  logic        gnt_vld;
  logic        gnt_id;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] rd_val;

  rr_pick2 u_pick (
    .req     ({s_req, c_req}),
    .last    (last_grant),
    .gnt_vld (gnt_vld),
    .winner  (gnt_id)
  );

  always_comb begin
    sel_we    = c_we;
    sel_addr  = c_addr;
    sel_wdata = c_wdata;
    if (gnt_id == OWN_S) begin
      sel_we    = s_we;
      sel_addr  = s_addr;
      sel_wdata = s_wdata;
    end
  end

  // Writes and rejected accesses return zero rather than whatever the array shows.
  assign rd_val = (we_q || err_q) ? 32'd0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= OWN_S;
      owner_q    <= OWN_C;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      c_rdata_q  <= 32'd0;
      s_rdata_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state   <= ST_ACCESS;
            owner_q <= gnt_id;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= addr_reject(sel_addr, DEPTH_WORDS);
          end
        end
        ST_ACCESS: begin
          state      <= ST_DONE;
          last_grant <= owner_q;
          if (owner_q == OWN_C) begin
            c_rdata_q <= rd_val;
          end else begin
            s_rdata_q <= rd_val;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every output decodes from registered state only.
  assign busy      = (state != ST_IDLE);
  assign mem_read  = (state == ST_ACCESS) && !we_q && !err_q;
  assign mem_write = (state == ST_ACCESS) && we_q && !err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign c_ack   = (state == ST_DONE) && (owner_q == OWN_C);
  assign s_ack   = (state == ST_DONE) && (owner_q == OWN_S);
  assign c_err   = c_ack && err_q;
  assign s_err   = s_ack && err_q;
  assign c_rdata = c_rdata_q;
  assign s_rdata = s_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small data memory model, a driver and
// a scoreboard monitor that checks every ack against queued expectations.
import dmem_arb_pkg::*;

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, s_req, s_we;
  logic [31:0] c_addr, c_wdata, s_addr, s_wdata;
  logic        c_ack, c_err, s_ack, s_err;
  logic [31:0] c_rdata, s_rdata;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic        preload;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter #(.DEPTH_WORDS(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .s_req     (s_req),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ack     (s_ack),
    .s_rdata   (s_rdata),
    .s_err     (s_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge, aliasing on bits [9:2].
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (c_ack || s_ack) begin
      exp_t e;
      check("single ack", {31'd0, c_ack && s_ack}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("grant owner", {31'd0, s_ack}, {31'd0, e.port});
        check("rdata", s_ack ? s_rdata : c_rdata, e.rdata);
        check("err", {31'd0, s_ack ? s_err : c_err}, {31'd0, e.err});
      end
    end
  end

  task automatic push_exp(input logic port, input logic [31:0] rd, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rd;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Single transaction on an otherwise idle arbiter.
  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err);
    int cyc = 0;
    logic got = 1'b0;
    push_exp(port, exp_rd, exp_err);
    if (port == OWN_C) begin
      c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
    end else begin
      s_we = we; s_addr = addr; s_wdata = wdata; s_req = 1'b1;
    end
    while (!got && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("mem_read in access", {31'd0, mem_read}, {31'd0, !we && !exp_err});
        check("mem_write in access", {31'd0, mem_write}, {31'd0, we && !exp_err});
      end
      got = (port == OWN_S) ? s_ack : c_ack;
    end
    check("req-to-ack latency", cyc, 2);
    @(posedge clk); #1;
    c_req = 1'b0;
    s_req = 1'b0;
  endtask

  // Waits for n acks, checking 3-cycle spacing; optionally drops each req after its ack.
  task automatic wait_acks(input int n, input logic drop);
    int   seen = 0;
    int   cyc = 0;
    int   last_cyc = -1;
    logic pc = 1'b0;
    logic ps = 1'b0;
    while (seen < n && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (drop && pc) c_req = 1'b0;
      if (drop && ps) s_req = 1'b0;
      pc = c_ack;
      ps = s_ack;
      if (c_ack || s_ack) begin
        if (last_cyc >= 0) check("ack spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        seen++;
      end
    end
    check("acks before timeout", seen, n);
    @(posedge clk); #1;
    c_req = 1'b0;
    s_req = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    preload = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'd0;
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h4;  s_wdata = 32'd0;

    // Reset held with both requests pending
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    check("reset c_ack", {31'd0, c_ack}, 32'd0);
    check("reset s_ack", {31'd0, s_ack}, 32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset mem_read", {31'd0, mem_read}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset c_rdata", c_rdata, 32'd0);

    // Release: C wins the first tie, then S
    push_exp(OWN_C, 32'hDEAD_BEEF, 1'b0);
    push_exp(OWN_S, 32'hA500_0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_acks(2, 1'b1);

    run_txn(OWN_C, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    run_txn(OWN_S, 1'b1, 32'h20, 32'h1234_5678, 32'd0, 1'b0);
    check("word 8 written", mem[8], 32'h1234_5678);
    run_txn(OWN_C, 1'b0, 32'h20, 32'd0, 32'h1234_5678, 1'b0);

    // Rejected writes: misaligned, then first out-of-range word
    run_txn(OWN_S, 1'b1, 32'h403, 32'hBAD0_BAD0, 32'd0, 1'b1);
    run_txn(OWN_S, 1'b1, 32'h400, 32'hBAD0_BAD0, 32'd0, 1'b1);
    check("word 0 untouched", mem[0], 32'hA500_0000);
    check("word 8 untouched", mem[8], 32'h1234_5678);

    // Continuous contention: C, S, C, S
    push_exp(OWN_C, 32'hDEAD_BEEF, 1'b0);
    push_exp(OWN_S, 32'h1234_5678, 1'b0);
    push_exp(OWN_C, 32'hDEAD_BEEF, 1'b0);
    push_exp(OWN_S, 32'h1234_5678, 1'b0);
    c_we = 1'b0; c_addr = 32'h10; c_req = 1'b1;
    s_we = 1'b0; s_addr = 32'h20; s_req = 1'b1;
    wait_acks(4, 1'b0);

    // Reset during the access cycle of a C write
    c_we = 1'b1; c_addr = 32'h8; c_wdata = 32'hCAFE_F00D; c_req = 1'b1;
    @(posedge clk); #1;
    check("mem_write before abort", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort mem_write", {31'd0, mem_write}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort no c_ack", {31'd0, c_ack}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("word 2 unchanged", mem[2], 32'hA500_0002);
    check("idle after abort", {31'd0, busy}, 32'd0);
    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the RISC-V core (port C) and the serial loader/debug engine (port S). It sits between both requesters and the data memory's MemRead/MemWrite/address/writeData/readData interface. It serialises accesses, alternates fairly under contention, and rejects misaligned or out-of-range addresses before they reach the array.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words in the data memory; legal byte addresses are 0 to DEPTH_WORDS*4-1.
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req / s_req  in  1  transaction request; held high until the matching ack
- c_we / s_we  in  1  1 = write, 0 = read; stable while req is high
- c_addr / s_addr  in  32  byte address; stable while req is high
- c_wdata / s_wdata  in  32  write data; stable while req is high
- c_ack / s_ack  out  1  one-cycle completion pulse
- c_rdata / s_rdata  out  32  read data; valid while ack is high
- c_err / s_err  out  1  valid with ack; 1 = rejected access (misaligned or out of range)
- mem_read  out  1  drives memory MemRead
- mem_write  out  1  drives memory MemWrite
- mem_addr  out  32  drives memory address
- mem_wdata  out  32  drives memory writeData
- mem_rdata  in  32  memory readData (combinational from the array)
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Sample c_req and s_req each edge.
  - If any req is high, pick a winner and latch its we/addr/wdata plus owner ID.
  - Compute err_q = (addr[1:0] != 0) or (addr >= DEPTH_WORDS*4).
  - Go to ACCESS.
- **Arbitration**
  - Only one requester active: it wins.
  - Both active: the port not granted last time wins (round-robin).
  - last_grant resets to S, so C wins the first tie.
- **ACCESS**
  - Drive mem_addr/mem_wdata from the latched registers.
  - mem_read = !we_q & !err_q; mem_write = we_q & !err_q.
  - At the closing edge, capture mem_rdata into the owner's rdata register. Rejected or write accesses load 0.
  - Update last_grant, go to DONE.
- **DONE**
  - Owner's ack = 1 and err = err_q. The other port's ack stays 0.
  - Next state is IDLE unconditionally.
  - The requester must drop req at the edge that closes DONE. A req still high in IDLE is a new transaction.
- **Outside ACCESS:** mem_read = mem_write = 0. mem_addr/mem_wdata keep their latched values and are don't-care.
- **Rejected access:** the memory is never written; ack still occurs with err = 1.
- **Reset values:**
  - State IDLE, last_grant = S.
  - All ack/err = 0; all rdata = 0.
  - mem_read = mem_write = 0; mem_addr = mem_wdata = 0; busy = 0.
- **Reset mid-operation:** asynchronous return to IDLE and outputs go to reset values immediately. A write in ACCESS is aborted: mem_write falls before the edge, so the memory is unchanged. The interrupted requester gets no ack and must re-request.
- **Request changes:** a req that drops while not granted is simply not served. A req that changes during its own transaction is ignored, because the latched copy is used.

## Timing
- Request sampled at edge E0 (IDLE → ACCESS).
- Memory accessed during cycle E0–E1; the write commits at E1.
- Ack is high during cycle E1–E2.
- Latency req-to-ack is 2 cycles; throughput is 1 transaction per 3 cycles.
- Under continuous contention, grants alternate C, S, C, S…; each port waits at most one extra transaction (3 cycles).
- All outputs are registered or decoded from registered state only. There is no combinational path from req to mem_* or ack.

## Structure
- Shared package dmem_arb_pkg holds:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - owner IDs (OWN_C = 1'b0, OWN_S = 1'b1);
  - the alignment/range check as a function.
- One sub-module, rr_pick2: a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last[0].
  - Outputs: grant valid, winner ID.
- The FSM, latches and output registers live in dmem_arbiter.

## Test plan
- Reset: hold rst_n = 0 with both reqs high → all acks 0, mem_write 0, busy 0; release → C served first.
- C read, addr 0x0000_0010, memory word 4 = 0xDEAD_BEEF → mem_read high one cycle later; c_ack, c_rdata = 0xDEADBEEF, c_err = 0 exactly 2 cycles after req; s_ack stays 0.
- S write 0x1234_5678 to 0x0000_0020, then C read of 0x20 → word 8 updated; c_rdata = 0x12345678.
- Both reqs held high for 4 transactions → grant order C, S, C, S; acks spaced 3 cycles apart; no double grant.
- S write to 0x0000_0403 (misaligned) and to 0x0000_0400 (out of range, DEPTH_WORDS = 256) → mem_write never asserts, s_err = 1 with s_ack, memory contents unchanged.
- Assert rst_n low during the ACCESS cycle of a C write to 0x8 → mem_write drops immediately, word 2 unchanged, no c_ack, FSM returns to IDLE.
